mem_dma_initiator: RTL

//  Requester for the scratchpad memory's dmem-style port (req_ready/valid/addr/data/fcn/typ,

---
 rtl/mem_dma_initiator.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_dma_initiator.sv
// Block-command requester (FILL / COPY / CHECK) for the scratchpad's dmem-style port.
// Optional feature: define MEM_DMA_PAT_INC_EN to make the FILL/CHECK pattern step by +1 per word.
module mem_dma_initiator #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_pattern,
  output logic          busy,
  output logic          done,
  output logic          mismatch,
  output logic [AW-1:0] fail_addr,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [AW-1:0] WORD_BYTES = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

`ifdef MEM_DMA_PAT_INC_EN
  localparam logic [DW-1:0] PAT_STEP = DW'(1);
`else
  localparam logic [DW-1:0] PAT_STEP = '0;
`endif

  state_t        state_reg, state_next;
  logic [1:0]    op_reg, op_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [LW-1:0] rem_reg, rem_next;
  logic [DW-1:0] pat_reg, pat_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          mismatch_reg, mismatch_next;
  logic [AW-1:0] fail_addr_reg, fail_addr_next;
  logic          rd_done;
  logic          last_word;

  assign mem_req_typ = 3'd3;
  assign mismatch    = mismatch_reg;
  assign fail_addr   = fail_addr_reg;
  assign last_word   = (rem_reg == LW'(1));

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    rem_next       = rem_reg;
    pat_next       = pat_reg;
    rdata_next     = rdata_reg;
    mismatch_next  = mismatch_reg;
    fail_addr_next = fail_addr_reg;
    rd_done        = 1'b0;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_fcn    = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;

    case (state_reg)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_next        = cmd_op;
          src_next       = cmd_src & ALIGN_MASK;
          dst_next       = cmd_dst & ALIGN_MASK;
          rem_next       = cmd_len;
          pat_next       = cmd_pattern;
          mismatch_next  = 1'b0;
          fail_addr_next = '0;
          if (cmd_len == '0 || cmd_op == OP_RSVD) begin
            state_next = S_FIN;
          end else if (cmd_op == OP_FILL) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end
      end

      S_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = src_reg;
        if (mem_req_ready) begin
          // A zero-wait memory answers in the accept cycle; otherwise park until it does.
          if (mem_resp_valid) begin
            rd_done = 1'b1;
          end else begin
            state_next = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (mem_resp_valid) begin
          rd_done = 1'b1;
        end
      end

      S_WR: begin
        mem_req_valid = 1'b1;
        mem_req_fcn   = 1'b1;
        mem_req_addr  = dst_reg;
        mem_req_data  = (op_reg == OP_FILL) ? pat_reg : rdata_reg;
        if (mem_req_ready) begin
          dst_next = dst_reg + WORD_BYTES;
          rem_next = rem_reg - LW'(1);
          if (op_reg == OP_COPY) begin
            src_next = src_reg + WORD_BYTES;
          end else begin
            pat_next = pat_reg + PAT_STEP;
          end
          if (last_word) begin
            state_next = S_FIN;
          end else if (op_reg == OP_FILL) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end
      end

      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (rd_done) begin
      if (op_reg == OP_COPY) begin
        rdata_next = mem_resp_data;
        state_next = S_WR;
      end else begin
        // CHECK keeps scanning after a miss; only the first address is reported.
        if (mem_resp_data != pat_reg && !mismatch_reg) begin
          mismatch_next  = 1'b1;
          fail_addr_next = src_reg;
        end
        src_next   = src_reg + WORD_BYTES;
        pat_next   = pat_reg + PAT_STEP;
        rem_next   = rem_reg - LW'(1);
        state_next = last_word ? S_FIN : S_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      src_reg       <= '0;
      dst_reg       <= '0;
      rem_reg       <= '0;
      pat_reg       <= '0;
      rdata_reg     <= '0;
      mismatch_reg  <= 1'b0;
      fail_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      rem_reg       <= rem_next;
      pat_reg       <= pat_next;
      rdata_reg     <= rdata_next;
      mismatch_reg  <= mismatch_next;
      fail_addr_reg <= fail_addr_next;
    end
  end

endmodule
